// File: rtl/tron_isa_pkg.sv
// Tron ISA encodings shared by the decoder: opcode/ext codes, ALU and
// shifter operation codes, decoder FSM states, and the mapping from an
// ALU-class opcode (or register-form ext) to its ALU operation.
package tron_isa_pkg;

  // Major opcodes in ir[15:12]. ALU-class ext values in ir[7:4] reuse
  // the immediate-form opcode numbers.
  localparam logic [3:0] OP_REG   = 4'h0;
  localparam logic [3:0] OP_ANDI  = 4'h1;
  localparam logic [3:0] OP_ORI   = 4'h2;
  localparam logic [3:0] OP_XORI  = 4'h3;
  localparam logic [3:0] OP_MEM   = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_SUBI  = 4'h9;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] OP_MOVI  = 4'hD;
  localparam logic [3:0] OP_NOP   = 4'hE;
  localparam logic [3:0] OP_LUI   = 4'hF;

  // Memory-form ext codes
  localparam logic [3:0] EXT_LOAD = 4'h0;
  localparam logic [3:0] EXT_STOR = 4'h4;

  typedef enum logic [3:0] {
    ALU_NONE = 4'h0,
    ALU_ADD  = 4'h1,
    ALU_SUB  = 4'h2,
    ALU_CMP  = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_MOV  = 4'h7,
    ALU_LUI  = 4'h8
  } alu_t;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_LDWB  = 2'd2
  } state_t;

  // ALU operation for an ALU-class code; ALU_NONE means not ALU-class.
  function automatic alu_t alu_of(input logic [3:0] code);
    case (code)
      OP_ADDI: return ALU_ADD;
      OP_SUBI: return ALU_SUB;
      OP_CMPI: return ALU_CMP;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_XORI: return ALU_XOR;
      OP_MOVI: return ALU_MOV;
      default: return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tron_decode_comb.sv
// Pure combinational Tron instruction decode: IR word to control bundle,
// plus is_load (two-beat sequencing needed) and is_illegal (undefined
// encoding). Undefined encodings always produce an all-disabled bundle.
module tron_decode_comb
  import tron_isa_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 4
) (
  input  logic [15:0]        ir,
  output logic [3:0]         alu_op,
  output logic               alu_src,
  output logic [RADDR_W-1:0] rd,
  output logic [RADDR_W-1:0] rs,
  output logic [DATA_W-1:0]  imm,
  output logic               reg_write,
  output logic               flags_write,
  output logic               shift_en,
  output logic [1:0]         shift_op,
  output logic [3:0]         shamt,
  output logic               mem_read,
  output logic               mem_write,
  output logic               is_load,
  output logic               is_illegal
);

  logic [3:0]               opcode;
  logic [3:0]               ext;
  alu_t                     alu_sel;
  logic                     sext_sel;
  logic signed [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0]        imm_zext;
  logic [DATA_W-1:0]        imm_lui;

  assign opcode   = ir[15:12];
  assign ext      = ir[7:4];
  assign alu_sel  = alu_of((opcode == OP_REG) ? ext : opcode);
  assign sext_sel = alu_sel inside {ALU_ADD, ALU_SUB, ALU_CMP, ALU_MOV};
  assign imm_sext = DATA_W'($signed(ir[7:0]));
  assign imm_zext = DATA_W'(ir[7:0]);
  assign imm_lui  = DATA_W'({ir[7:0], 8'h00});

  // Opcode-driven decode; everything defaults to a disabled bundle.
  always_comb begin
    alu_op      = ALU_NONE;
    alu_src     = 1'b0;
    rd          = RADDR_W'(ir[11:8]);
    rs          = RADDR_W'(ir[3:0]);
    imm         = '0;
    reg_write   = 1'b0;
    flags_write = 1'b0;
    shift_en    = 1'b0;
    shift_op    = SH_LSL;
    shamt       = 4'h0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    is_load     = 1'b0;
    is_illegal  = 1'b0;
    case (opcode)
      OP_REG, OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI, OP_ANDI, OP_ORI, OP_XORI: begin
        if (alu_sel == ALU_NONE) begin
          is_illegal = 1'b1;
        end else begin
          alu_op      = alu_sel;
          alu_src     = (opcode != OP_REG);
          reg_write   = (alu_sel != ALU_CMP);
          flags_write = alu_sel inside {ALU_ADD, ALU_SUB, ALU_CMP};
          if (opcode != OP_REG) imm = sext_sel ? imm_sext : imm_zext;
        end
      end
      OP_LUI: begin
        alu_op    = ALU_LUI;
        alu_src   = 1'b1;
        imm       = imm_lui;
        reg_write = 1'b1;
      end
      OP_SHIFT: begin
        if (ir[5:4] != 2'b00) begin
          is_illegal = 1'b1;
        end else begin
          shift_en  = 1'b1;
          shift_op  = ir[7:6];
          shamt     = ir[3:0];
          reg_write = 1'b1;
        end
      end
      OP_MEM: begin
        if (ext == EXT_LOAD) begin
          mem_read = 1'b1;
          is_load  = 1'b1;
        end else if (ext == EXT_STOR) begin
          mem_write = 1'b1;
        end else begin
          is_illegal = 1'b1;
        end
      end
      OP_NOP: ;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/tron_decode_seq.sv
// Registered, handshaked Tron instruction decoder. Accepts one IR word per
// ir_valid/ir_ready handshake, presents the decoded bundle one cycle later
// under ctrl_valid/ctrl_ready, and sequences LOAD as two beats (address
// beat, then memory write-back beat).
// Optional feature macro TRON_DECODE_ILLEGAL_TRAP_EN: when defined, an
// undefined encoding raises a sticky `illegal` flag and halts the decoder
// until reset; when undefined, such encodings issue as NOPs.
module tron_decode_seq
  import tron_isa_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ir_valid,
  input  logic [15:0]        ir,
  output logic               ir_ready,
  output logic               ctrl_valid,
  input  logic               ctrl_ready,
  output logic [3:0]         alu_op,
  output logic               alu_src,
  output logic [RADDR_W-1:0] rd,
  output logic [RADDR_W-1:0] rs,
  output logic [DATA_W-1:0]  imm,
  output logic               reg_write,
  output logic               flags_write,
  output logic               shift_en,
  output logic [1:0]         shift_op,
  output logic [3:0]         shamt,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_mem,
  output logic               illegal
);

  // Stage p0: combinational decode of the offered IR word
  logic [3:0]         alu_op_p0;
  logic               alu_src_p0;
  logic [RADDR_W-1:0] rd_p0;
  logic [RADDR_W-1:0] rs_p0;
  logic [DATA_W-1:0]  imm_p0;
  logic               reg_write_p0;
  logic               flags_write_p0;
  logic               shift_en_p0;
  logic [1:0]         shift_op_p0;
  logic [3:0]         shamt_p0;
  logic               mem_read_p0;
  logic               mem_write_p0;
  logic               is_load_p0;
  logic               is_illegal_p0;

  tron_decode_comb #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W)
  ) u_decode (
    .ir          (ir),
    .alu_op      (alu_op_p0),
    .alu_src     (alu_src_p0),
    .rd          (rd_p0),
    .rs          (rs_p0),
    .imm         (imm_p0),
    .reg_write   (reg_write_p0),
    .flags_write (flags_write_p0),
    .shift_en    (shift_en_p0),
    .shift_op    (shift_op_p0),
    .shamt       (shamt_p0),
    .mem_read    (mem_read_p0),
    .mem_write   (mem_write_p0),
    .is_load     (is_load_p0),
    .is_illegal  (is_illegal_p0)
  );

  // Stage p1: registered control bundle and handshake state
  state_t             state_q;
  state_t             state_d;
  logic               vld_p1;
  logic [3:0]         alu_op_p1;
  logic               alu_src_p1;
  logic [RADDR_W-1:0] rd_p1;
  logic [RADDR_W-1:0] rs_p1;
  logic [DATA_W-1:0]  imm_p1;
  logic               reg_write_p1;
  logic               flags_write_p1;
  logic               shift_en_p1;
  logic [1:0]         shift_op_p1;
  logic [3:0]         shamt_p1;
  logic               mem_read_p1;
  logic               mem_write_p1;
  logic               wb_mem_p1;
  logic               load_p1;
  logic               ready;
  logic               accept;
  logic               to_ldwb;
  logic               halt;

`ifdef TRON_DECODE_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky trap flag: set when an undefined word is taken, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else if (accept && is_illegal_p0) illegal_q <= 1'b1;
  end

  assign halt    = illegal_q;
  assign illegal = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = is_illegal_p0;
  assign halt           = 1'b0;
  assign illegal        = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else state_q <= state_d;
  end

  // Next state and ir_ready; a new word may enter as the last beat leaves.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    to_ldwb = 1'b0;
    case (state_q)
      ST_IDLE: ready = 1'b1;
      ST_ISSUE: begin
        if (ctrl_ready) begin
          if (load_p1) begin
            state_d = ST_LDWB;
            to_ldwb = 1'b1;
          end else begin
            state_d = ST_IDLE;
            ready   = 1'b1;
          end
        end
      end
      ST_LDWB: begin
        if (ctrl_ready) begin
          state_d = ST_IDLE;
          ready   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (halt) ready = 1'b0;
    accept = ir_valid && ready;
    if (accept) state_d = ST_ISSUE;
  end

  // Bundle registers: load on accept, rewrite for the LOAD write-back beat,
  // clear whenever nothing is left to present; hold otherwise.
  always_ff @(posedge clk) begin
    if (reset || state_d == ST_IDLE) begin
      alu_op_p1      <= '0;
      alu_src_p1     <= 1'b0;
      rd_p1          <= '0;
      rs_p1          <= '0;
      imm_p1         <= '0;
      reg_write_p1   <= 1'b0;
      flags_write_p1 <= 1'b0;
      shift_en_p1    <= 1'b0;
      shift_op_p1    <= '0;
      shamt_p1       <= '0;
      mem_read_p1    <= 1'b0;
      mem_write_p1   <= 1'b0;
      wb_mem_p1      <= 1'b0;
      load_p1        <= 1'b0;
    end else if (accept) begin
      alu_op_p1      <= alu_op_p0;
      alu_src_p1     <= alu_src_p0;
      rd_p1          <= rd_p0;
      rs_p1          <= rs_p0;
      imm_p1         <= imm_p0;
      reg_write_p1   <= reg_write_p0;
      flags_write_p1 <= flags_write_p0;
      shift_en_p1    <= shift_en_p0;
      shift_op_p1    <= shift_op_p0;
      shamt_p1       <= shamt_p0;
      mem_read_p1    <= mem_read_p0;
      mem_write_p1   <= mem_write_p0;
      wb_mem_p1      <= 1'b0;
      load_p1        <= is_load_p0;
    end else if (to_ldwb) begin
      mem_read_p1  <= 1'b0;
      reg_write_p1 <= 1'b1;
      wb_mem_p1    <= 1'b1;
      load_p1      <= 1'b0;
    end
  end

  assign vld_p1      = (state_q != ST_IDLE);
  assign ctrl_valid  = vld_p1;
  assign ir_ready    = ready;
  assign alu_op      = alu_op_p1;
  assign alu_src     = alu_src_p1;
  assign rd          = rd_p1;
  assign rs          = rs_p1;
  assign imm         = imm_p1;
  assign reg_write   = reg_write_p1;
  assign flags_write = flags_write_p1;
  assign shift_en    = shift_en_p1;
  assign shift_op    = shift_op_p1;
  assign shamt       = shamt_p1;
  assign mem_read    = mem_read_p1;
  assign mem_write   = mem_write_p1;
  assign wb_mem      = wb_mem_p1;

endmodule

// File: tb/tb_tron_decode_seq.sv
// Testbench for tron_decode_seq: directed steps from the test plan, then a
// randomized phase scored against an instruction-level reference model
// (a queue of expected beats per accepted word). Follows the build setting
// of TRON_DECODE_ILLEGAL_TRAP_EN.
module tb_tron_decode_seq;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] imm;
    logic        reg_write;
    logic        flags_write;
    logic        shift_en;
    logic [1:0]  shift_op;
    logic [3:0]  shamt;
    logic        mem_read;
    logic        mem_write;
    logic        wb_mem;
  } bundle_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ir_valid;
  logic [15:0] ir;
  logic        ir_ready;
  logic        ctrl_valid;
  logic        ctrl_ready;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [15:0] imm;
  logic        reg_write;
  logic        flags_write;
  logic        shift_en;
  logic [1:0]  shift_op;
  logic [3:0]  shamt;
  logic        mem_read;
  logic        mem_write;
  logic        wb_mem;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;
  bundle_t q[$];

  tron_decode_seq #(.DATA_W(16), .RADDR_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .ir_valid    (ir_valid),
    .ir          (ir),
    .ir_ready    (ir_ready),
    .ctrl_valid  (ctrl_valid),
    .ctrl_ready  (ctrl_ready),
    .alu_op      (alu_op),
    .alu_src     (alu_src),
    .rd          (rd),
    .rs          (rs),
    .imm         (imm),
    .reg_write   (reg_write),
    .flags_write (flags_write),
    .shift_en    (shift_en),
    .shift_op    (shift_op),
    .shamt       (shamt),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .wb_mem      (wb_mem),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  // Reference decode written from the instruction tables.
  function automatic bundle_t model(input logic [15:0] w, output bit ld, output bit bad);
    bundle_t     b;
    logic [15:0] sx;
    logic [15:0] zx;
    b   = '0;
    sx  = {{8{w[7]}}, w[7:0]};
    zx  = {8'h00, w[7:0]};
    ld  = 1'b0;
    bad = 1'b0;
    b.rd = w[11:8];
    b.rs = w[3:0];
    case (w[15:12])
      4'h5: begin b.alu_op = 4'd1; b.alu_src = 1; b.imm = sx; b.reg_write = 1; b.flags_write = 1; end
      4'h9: begin b.alu_op = 4'd2; b.alu_src = 1; b.imm = sx; b.reg_write = 1; b.flags_write = 1; end
      4'hB: begin b.alu_op = 4'd3; b.alu_src = 1; b.imm = sx; b.flags_write = 1; end
      4'hD: begin b.alu_op = 4'd7; b.alu_src = 1; b.imm = sx; b.reg_write = 1; end
      4'h1: begin b.alu_op = 4'd4; b.alu_src = 1; b.imm = zx; b.reg_write = 1; end
      4'h2: begin b.alu_op = 4'd5; b.alu_src = 1; b.imm = zx; b.reg_write = 1; end
      4'h3: begin b.alu_op = 4'd6; b.alu_src = 1; b.imm = zx; b.reg_write = 1; end
      4'hF: begin b.alu_op = 4'd8; b.alu_src = 1; b.imm = {w[7:0], 8'h00}; b.reg_write = 1; end
      4'h0: begin
        case (w[7:4])
          4'h5: begin b.alu_op = 4'd1; b.reg_write = 1; b.flags_write = 1; end
          4'h9: begin b.alu_op = 4'd2; b.reg_write = 1; b.flags_write = 1; end
          4'hB: begin b.alu_op = 4'd3; b.flags_write = 1; end
          4'hD: begin b.alu_op = 4'd7; b.reg_write = 1; end
          4'h1: begin b.alu_op = 4'd4; b.reg_write = 1; end
          4'h2: begin b.alu_op = 4'd5; b.reg_write = 1; end
          4'h3: begin b.alu_op = 4'd6; b.reg_write = 1; end
          default: bad = 1'b1;
        endcase
      end
      4'h8: begin
        if (w[5:4] != 2'b00) bad = 1'b1;
        else begin b.shift_en = 1; b.shift_op = w[7:6]; b.shamt = w[3:0]; b.reg_write = 1; end
      end
      4'h4: begin
        if (w[7:4] == 4'h0) begin b.mem_read = 1; ld = 1'b1; end
        else if (w[7:4] == 4'h4) b.mem_write = 1;
        else bad = 1'b1;
      end
      4'hE: ;
      default: bad = 1'b1;
    endcase
    return b;
  endfunction

  function automatic bundle_t beat2(input bundle_t b);
    bundle_t r;
    r           = b;
    r.mem_read  = 1'b0;
    r.reg_write = 1'b1;
    r.wb_mem    = 1'b1;
    return r;
  endfunction

  function automatic bundle_t observed();
    bundle_t b;
    b.alu_op      = alu_op;
    b.alu_src     = alu_src;
    b.rd          = rd;
    b.rs          = rs;
    b.imm         = imm;
    b.reg_write   = reg_write;
    b.flags_write = flags_write;
    b.shift_en    = shift_en;
    b.shift_op    = shift_op;
    b.shamt       = shamt;
    b.mem_read    = mem_read;
    b.mem_write   = mem_write;
    b.wb_mem      = wb_mem;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    bundle_t b;
    bit      ld;
    bit      bad;

    reset = 1'b1; ir_valid = 1'b0; ir = 16'h0000; ctrl_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", 64'(ctrl_valid), 64'd0);
    chk("rst_ready", 64'(ir_ready), 64'd1);
    chk("rst_bundle", 64'(observed()), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);

    // ADDI with sign-extended immediate
    ir_valid = 1'b1; ir = 16'h5AF0; ctrl_ready = 1'b1;
    tick();
    ir_valid = 1'b0;
    b = model(16'h5AF0, ld, bad);
    chk("addi_valid", 64'(ctrl_valid), 64'd1);
    chk("addi_bundle", 64'(observed()), 64'(b));
    chk("addi_imm", 64'(imm), 64'h0000_0000_0000_FFF0);
    tick();
    chk("addi_done", 64'(ctrl_valid), 64'd0);

    // ANDI then register CMP back-to-back
    ir_valid = 1'b1; ir = 16'h13F0;
    tick();
    ir = 16'h02B3;
    #1;
    chk("b2b_ready", 64'(ir_ready), 64'd1);
    b = model(16'h13F0, ld, bad);
    chk("andi_bundle", 64'(observed()), 64'(b));
    chk("andi_imm", 64'(imm), 64'h0000_0000_0000_00F0);
    tick();
    ir_valid = 1'b0;
    b = model(16'h02B3, ld, bad);
    chk("cmp_valid", 64'(ctrl_valid), 64'd1);
    chk("cmp_bundle", 64'(observed()), 64'(b));
    chk("cmp_fields", 64'({alu_op, alu_src, reg_write, flags_write}), 64'({4'b0011, 1'b0, 1'b0, 1'b1}));
    tick();
    chk("cmp_done", 64'(ctrl_valid), 64'd0);

    // LOAD: two beats
    ir_valid = 1'b1; ir = 16'h4203;
    tick();
    ir_valid = 1'b0;
    #1;
    b = model(16'h4203, ld, bad);
    chk("ld1_bundle", 64'(observed()), 64'(b));
    chk("ld1_memrd", 64'({mem_read, reg_write}), 64'(2'b10));
    chk("ld1_ready", 64'(ir_ready), 64'd0);
    tick();
    chk("ld2_valid", 64'(ctrl_valid), 64'd1);
    chk("ld2_bundle", 64'(observed()), 64'(beat2(b)));
    chk("ld2_fields", 64'({reg_write, wb_mem, rd}), 64'({1'b1, 1'b1, 4'h2}));
    chk("ld2_ready", 64'(ir_ready), 64'd1);
    tick();
    chk("ld_done", 64'(ctrl_valid), 64'd0);

    // LSL held under back-pressure while another word waits
    ir_valid = 1'b1; ir = 16'h8305; ctrl_ready = 1'b0;
    tick();
    ir = 16'h5123;
    b = model(16'h8305, ld, bad);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_valid", 64'(ctrl_valid), 64'd1);
      chk("bp_bundle", 64'(observed()), 64'(b));
      chk("bp_shift", 64'({shift_op, shamt}), 64'({2'b00, 4'h5}));
      chk("bp_ready", 64'(ir_ready), 64'd0);
      tick();
    end
    ctrl_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(ir_ready), 64'd1);
    tick();
    ir_valid = 1'b0;
    b = model(16'h5123, ld, bad);
    chk("bp_next_bundle", 64'(observed()), 64'(b));
    tick();
    chk("bp_done", 64'(ctrl_valid), 64'd0);

    // Randomized traffic against the beat-queue model
    q.delete();
    for (int c = 0; c < 400; c++) begin
      bit          v;
      bit          r;
      bit          exp_valid;
      bit          exp_ready;
      logic [15:0] w;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      w = 16'($urandom);
`ifdef TRON_DECODE_ILLEGAL_TRAP_EN
      b = model(w, ld, bad);
      for (int k = 0; k < 16; k++) begin
        if (bad) begin
          w = 16'($urandom);
          b = model(w, ld, bad);
        end
      end
      if (bad) w = 16'hE000;
`endif
      ir_valid = v; ir = w; ctrl_ready = r;
      #1;
      exp_valid = (q.size() != 0);
      exp_ready = (q.size() == 0) || (q.size() == 1 && r);
      chk("rnd_valid", 64'(ctrl_valid), 64'(exp_valid));
      chk("rnd_ready", 64'(ir_ready), 64'(exp_ready));
      chk("rnd_illegal", 64'(illegal), 64'd0);
      if (exp_valid) chk("rnd_bundle", 64'(observed()), 64'(q[0]));
      if (exp_valid && r) void'(q.pop_front());
      if (v && exp_ready) begin
        b = model(w, ld, bad);
        q.push_back(b);
        if (ld) q.push_back(beat2(b));
      end
      tick();
    end
    ir_valid = 1'b0; ctrl_ready = 1'b1;
    repeat (3) tick();
    q.delete();
    chk("rnd_drained", 64'(ctrl_valid), 64'd0);

    // Undefined encoding
    ir_valid = 1'b1; ir = 16'h0F00;
    tick();
    ir_valid = 1'b0;
    #1;
    b = model(16'h0F00, ld, bad);
    chk("und_valid", 64'(ctrl_valid), 64'd1);
    chk("und_bundle", 64'(observed()), 64'(b));
    chk("und_enables", 64'({reg_write, flags_write, shift_en, mem_read, mem_write, wb_mem}), 64'd0);
`ifdef TRON_DECODE_ILLEGAL_TRAP_EN
    chk("und_illegal", 64'(illegal), 64'd1);
    chk("und_ready", 64'(ir_ready), 64'd0);
    tick();
    chk("halt_valid", 64'(ctrl_valid), 64'd0);
    chk("halt_ready", 64'(ir_ready), 64'd0);
    ir_valid = 1'b1; ir = 16'h5AF0;
    repeat (2) tick();
    ir_valid = 1'b0;
    chk("halt_no_issue", 64'(ctrl_valid), 64'd0);
    chk("halt_sticky", 64'(illegal), 64'd1);
`else
    chk("und_illegal", 64'(illegal), 64'd0);
    chk("und_ready", 64'(ir_ready), 64'd1);
    tick();
    chk("und_done", 64'(ctrl_valid), 64'd0);
    chk("und_flow", 64'(ir_ready), 64'd1);
`endif

    // Reset while in the LOAD write-back beat
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ir_valid = 1'b1; ir = 16'h4A03; ctrl_ready = 1'b1;
    tick();
    ir_valid = 1'b0;
    tick();
    chk("ldwb_reached", 64'({ctrl_valid, wb_mem, rd}), 64'({1'b1, 1'b1, 4'hA}));
    ctrl_ready = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_ldwb_valid", 64'(ctrl_valid), 64'd0);
    chk("rst_ldwb_bundle", 64'(observed()), 64'd0);
    chk("rst_ldwb_ready", 64'(ir_ready), 64'd1);
    chk("rst_ldwb_illegal", 64'(illegal), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
